// File: rtl/wire_ops_pkg.sv
// rtl/wire_ops_pkg.sv - shared opcode enum and widths for wire_ops_pipe
package wire_ops_pkg;

    localparam int OP_W  = 3;
    localparam int CNT_W = 16;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_XOR  = 3'b001,
        OP_OR   = 3'b010,
        OP_ADD  = 3'b011,
        OP_SUB  = 3'b100,
        OP_ACC  = 3'b101,
        OP_PASS = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/pyc_fifo.sv
// rtl/pyc_fifo.sv - synchronous power-of-two FIFO with stream handshakes
module pyc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] in_tdata,
    input  logic             in_tvalid,
    output logic             in_tready,
    output logic [WIDTH-1:0] out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push;
    logic             pop;

    // Full/empty come straight from the registered count, so ready never
    // depends combinationally on the opposite side of the queue.
    assign in_tready  = (count_q != FULL_CNT);
    assign out_tvalid = (count_q != '0);
    assign out_tdata  = mem_q[rd_ptr_q];
    assign push       = in_tvalid && in_tready;
    assign pop        = out_tvalid && out_tready;

    // Pointer and occupancy update; push+pop together leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage write on push.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_tdata;
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array needs no reset; the count gates what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/wire_ops_pipe.sv
// rtl/wire_ops_pipe.sv - ALU with accumulator, one register stage and output queue
module wire_ops_pipe
    import wire_ops_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_carry,
    output logic             y_zero,
    output logic [CNT_W-1:0] op_count
);

    localparam int QW = WIDTH + 2;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_y_q, s1_y_d;
    logic             s1_carry_q, s1_carry_d;
    logic             s1_zero_q, s1_zero_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   acc_sum;

    logic             accept;
    logic             fifo_in_ready;
    logic [QW-1:0]    fifo_in_data;
    logic [QW-1:0]    fifo_out_data;
    logic             fifo_out_valid;

    // S1 can take a beat if it is empty or it drains into the queue this edge.
    assign in_ready = !s1_valid_q || fifo_in_ready;
    assign accept   = in_valid && in_ready;

    // Operation decode; acc_clr makes ACC start from zero.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        acc_base  = acc_clr ? '0 : acc_q;
        add_sum   = {1'b0, a} + {1'b0, b};
        acc_sum   = {1'b0, acc_base} + {1'b0, a};
        case (op_e'(op))
            OP_AND:  alu_res = a & b;
            OP_XOR:  alu_res = a ^ b;
            OP_OR:   alu_res = a | b;
            OP_ADD: begin
                alu_res   = add_sum[WIDTH-1:0];
                alu_carry = add_sum[WIDTH];
            end
            OP_SUB: begin
                alu_res   = a - b;
                alu_carry = (a < b);
            end
            OP_ACC: begin
                alu_res   = acc_sum[WIDTH-1:0];
                alu_carry = acc_sum[WIDTH];
            end
            OP_PASS: alu_res = a;
            default: alu_res = '0;
        endcase
    end

    // S1, accumulator and request counter next-state.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_y_d     = s1_y_q;
        s1_carry_d = s1_carry_q;
        s1_zero_d  = s1_zero_q;
        acc_d      = acc_q;
        op_count_d = op_count_q;
        if (s1_valid_q && fifo_in_ready) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_y_d     = alu_res;
            s1_carry_d = alu_carry;
            s1_zero_d  = (alu_res == '0);
            if (op_e'(op) == OP_ACC) begin
                acc_d = alu_res;
            end else if (acc_clr) begin
                acc_d = '0;
            end
            if (op_count_q != CNT_MAX) begin
                op_count_d = op_count_q + 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            s1_valid_q <= 1'b0;
            s1_y_q     <= '0;
            s1_carry_q <= 1'b0;
            s1_zero_q  <= 1'b1;
            acc_q      <= '0;
            op_count_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_y_q     <= s1_y_d;
            s1_carry_q <= s1_carry_d;
            s1_zero_q  <= s1_zero_d;
            acc_q      <= acc_d;
            op_count_q <= op_count_d;
        end
    end

    assign fifo_in_data = {s1_carry_q, s1_zero_q, s1_y_q};

    pyc_fifo #(
        .WIDTH (QW),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk        (sys_clk),
        .resetn     (sys_rst),
        .in_tdata   (fifo_in_data),
        .in_tvalid  (s1_valid_q),
        .in_tready  (fifo_in_ready),
        .out_tdata  (fifo_out_data),
        .out_tvalid (fifo_out_valid),
        .out_tready (out_ready)
    );

    // Head is masked when empty so idle outputs read as a clean zero result.
    assign out_valid = fifo_out_valid;
    assign y         = fifo_out_valid ? fifo_out_data[WIDTH-1:0] : '0;
    assign y_zero    = fifo_out_valid ? fifo_out_data[WIDTH] : 1'b1;
    assign y_carry   = fifo_out_valid ? fifo_out_data[WIDTH+1] : 1'b0;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_wire_ops_pipe.sv
// tb/tb_wire_ops_pipe.sv - vector table and scoreboard bench for wire_ops_pipe
module tb_wire_ops_pipe;
    import wire_ops_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         sys_rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         y_carry;
    logic         y_zero;
    logic [15:0]  op_count;

    typedef struct packed {
        logic [W-1:0] y;
        logic         c;
        logic         z;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         clr;
        logic [W-1:0] ey;
        logic         ec;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    int   sent   = 0;

    always #5 clk = ~clk;

    wire_ops_pipe #(.WIDTH(W), .FIFO_DEPTH(4)) dut (
        .sys_clk   (clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_carry   (y_carry),
        .y_zero    (y_zero),
        .op_count  (op_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every popped head must match the oldest expected result.
    exp_t mon_e;
    always @(negedge clk) begin
        if (sys_rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got y=%0h expected no output", y);
            end else begin
                mon_e = sb.pop_front();
                chk("scoreboard {c,z,y}", {22'd0, y_carry, y_zero, y}, {22'd0, mon_e.c, mon_e.z, mon_e.y});
                popped++;
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic clr, input logic [W-1:0] ey, input logic ec);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        op       = o;
        a        = aa;
        b        = bb;
        acc_clr  = clr;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (ok) begin
            sb.push_back('{y: ey, c: ec, z: (ey == '0)});
            sent++;
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_acc;
        int   pop0;
        bit   stale;

        vecs[0]  = '{OP_ADD,  8'hF0, 8'h20, 1'b0, 8'h10, 1'b1};
        vecs[1]  = '{OP_SUB,  8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
        vecs[2]  = '{OP_SUB,  8'h33, 8'h33, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{OP_ACC,  8'h00, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[4]  = '{OP_ACC,  8'h80, 8'h00, 1'b0, 8'h80, 1'b0};
        vecs[5]  = '{OP_ACC,  8'h80, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[6]  = '{OP_ACC,  8'h01, 8'h00, 1'b0, 8'h01, 1'b0};
        vecs[7]  = '{OP_ACC,  8'h05, 8'h00, 1'b1, 8'h05, 1'b0};
        vecs[8]  = '{OP_ADD,  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[9]  = '{OP_ACC,  8'h03, 8'h00, 1'b0, 8'h08, 1'b0};
        vecs[10] = '{OP_AND,  8'h3C, 8'h0F, 1'b1, 8'h0C, 1'b0};
        vecs[11] = '{OP_ACC,  8'h11, 8'h00, 1'b0, 8'h11, 1'b0};
        vecs[12] = '{OP_PASS, 8'hA5, 8'h5A, 1'b0, 8'hA5, 1'b0};
        vecs[13] = '{OP_RSVD, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[14] = '{OP_XOR,  8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0};
        vecs[15] = '{OP_OR,   8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

        // Reset with a request held active: it must be ignored.
        sys_rst   = 1'b0;
        in_valid  = 1'b1;
        op        = OP_PASS;
        a         = 8'h55;
        b         = 8'h00;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sys_rst  = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_op_count",  {16'd0, op_count},  32'd0);
        chk("rst_y_zero",    {31'd0, y_zero},    32'd1);
        chk("rst_y",         {24'd0, y},         32'd0);
        chk("rst_y_carry",   {31'd0, y_carry},   32'd0);

        send(OP_ACC, 8'h07, 8'h00, 1'b0, 8'h07, 1'b0);
        idle();
        drain("drain_first_acc");

        // Logic ops back to back with a latency probe on the first beat.
        @(posedge clk);
        #1;
        in_valid = 1'b1; op = OP_AND; a = 8'h0F; b = 8'hF5;
        @(negedge clk);
        chk("lat_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back('{y: 8'h05, c: 1'b0, z: 1'b0}); sent++;
        @(posedge clk);
        #1;
        op = OP_XOR;
        @(negedge clk);
        chk("lat_edge1_valid", {31'd0, out_valid}, 32'd0);
        sb.push_back('{y: 8'hFA, c: 1'b0, z: 1'b0}); sent++;
        @(posedge clk);
        #1;
        op = OP_OR;
        @(negedge clk);
        chk("lat_edge2_valid", {31'd0, out_valid}, 32'd1);
        sb.push_back('{y: 8'hFF, c: 1'b0, z: 1'b0}); sent++;
        idle();
        drain("drain_logic");

        for (int i = 0; i < 16; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].clr, vecs[i].ey, vecs[i].ec);
        end
        idle();
        drain("drain_table");

        // Backpressure: five beats fit (queue plus S1), then ready drops.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = OP_PASS;
        a         = 8'h40;
        b         = 8'h00;
        n_acc     = 0;
        pop0      = popped;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{y: a, c: 1'b0, z: (a == '0)});
                sent++;
                n_acc++;
                @(posedge clk);
                #1;
                a = a + 8'h01;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("bp_accepted", n_acc, 32'd5);
        @(negedge clk);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_head", {24'd0, y}, 32'h40);
        repeat (3) @(negedge clk);
        chk("bp_head_hold", {24'd0, y}, 32'h40);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(OP_PASS, 8'h45 + 8'(i), 8'h00, 1'b0, 8'h45 + 8'(i), 1'b0);
        end
        idle();
        drain("drain_bp");
        chk("bp_popped", popped - pop0, 32'd9);
        @(negedge clk);
        chk("op_count_total", {16'd0, op_count}, sent);

        // Reset with results queued: nothing from before may reappear.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(OP_PASS, 8'h61, 8'h00, 1'b0, 8'h61, 1'b0);
        send(OP_PASS, 8'h62, 8'h00, 1'b0, 8'h62, 1'b0);
        send(OP_PASS, 8'h63, 8'h00, 1'b0, 8'h63, 1'b0);
        idle();
        repeat (3) @(negedge clk);
        chk("mid_queued_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        sys_rst  = 1'b0;
        in_valid = 1'b1;
        op       = OP_PASS;
        a        = 8'h99;
        sb.delete();
        sent     = 0;
        @(posedge clk);
        #1;
        sys_rst   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_op_count",  {16'd0, op_count},  32'd0);
        chk("mid_in_ready",  {31'd0, in_ready},  32'd1);
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("mid_no_stale", {31'd0, stale}, 32'd0);
        send(OP_ACC, 8'h07, 8'h00, 1'b0, 8'h07, 1'b0);
        idle();
        drain("drain_after_mid_reset");
        chk("mid_op_count_after", {16'd0, op_count}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wire_ops_pipe.md
WIRE_OPS_PIPE -- requirements
Module: wire_ops_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width, legal range 2..64.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output queue entries, power of two, at least 2.
REQ-003 SHALL have port sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port sys_rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request present.
REQ-006 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port op  input  3  opcode.
REQ-010 SHALL have port acc_clr  input  1  clear accumulator; sampled only on an accepted beat.
REQ-011 SHALL have port out_valid  output  1  result at queue head.
REQ-012 SHALL have port out_ready  input  1  consumer takes the head result.
REQ-013 SHALL have port y  output  WIDTH  result.
REQ-014 SHALL have port y_carry  output  1  carry or borrow flag of the head result.
REQ-015 SHALL have port y_zero  output  1  high when y equals 0.
REQ-016 SHALL have port op_count  output  16  count of accepted requests.

Function
REQ-017 SHALL define an accepted beat as in_valid=1 and in_ready=1 at a rising edge.
REQ-018 SHALL decode op as follows, with y_carry=0 unless stated:
- 000 AND: a&b.
- 001 XOR: a^b.
- 010 OR: a|b.
- 011 ADD: a+b mod 2^WIDTH; carry = bit WIDTH of the sum.
- 100 SUB: a-b mod 2^WIDTH; carry = borrow (a<b).
- 101 ACC: acc+a mod 2^WIDTH; carry = bit WIDTH of the sum; acc takes the result.
- 110 PASS: a.
- 111 reserved: result 0.
REQ-019 SHALL hold the WIDTH-bit accumulator acc unchanged except on an accepted ACC beat or an accepted acc_clr.
REQ-020 SHALL set acc to 0 on an accepted beat with acc_clr=1 and op other than ACC.
REQ-021 SHALL treat an accepted beat with acc_clr=1 and op=ACC as 0+a: result a, carry 0, acc=a.
REQ-022 SHALL register the computed result, flags and a valid bit into stage S1 on each accepted beat.
REQ-023 SHALL push S1 into the output FIFO at the next edge if the FIFO is not full; otherwise S1 SHALL hold.
REQ-024 SHALL drive in_ready = (S1 empty) OR (FIFO not full), using registered state only, with no combinational path from out_ready.
REQ-025 SHALL have a minimum latency of 2 edges: a beat accepted at edge k gives out_valid=1 after edge k+1.
REQ-026 SHALL drive out_valid = FIFO not empty and present y, y_carry, y_zero from the FIFO head.
REQ-027 SHALL pop the FIFO when out_valid=1 and out_ready=1.
REQ-028 SHALL leave occupancy unchanged on a simultaneous push and pop.
REQ-029 SHALL never push when the FIFO is full, even if a pop occurs in the same cycle.
REQ-030 SHALL deliver results in acceptance order, with no loss or duplication.
REQ-031 SHALL increment op_count on each accepted beat and saturate it at 16'hFFFF.
REQ-032 SHALL hold y stable while out_valid=1 and out_ready=0.

Reset
REQ-033 SHALL, on sys_rst=0 at a rising edge, clear S1, the FIFO pointers and occupancy, acc and op_count.
REQ-034 SHALL present out_valid=0, y=0, y_carry=0, y_zero=1, op_count=0 and in_ready=1 after reset.
REQ-035 SHALL discard in-flight results when reset is applied mid-operation, and SHALL ignore in_valid during reset.

Structure
REQ-036 SHALL take the opcode enum, opcode width (3) and counter width (16) from shared package wire_ops_pkg.
REQ-037 SHALL implement the output queue as one instance of the existing pyc_fifo, with width WIDTH+2 and depth FIFO_DEPTH.
REQ-038 SHALL keep the ALU decode and S1 in the top module.

Verification (WIDTH=8, FIFO_DEPTH=4)
REQ-039 Reset: out_valid=0, in_ready=1, op_count=0, y_zero=1; a following ACC a=0x07 gives y=0x07.
REQ-040 Logic: a=0x0F, b=0xF5 with AND, XOR, OR gives 0x05, 0xFA, 0xFF in order, first out_valid 2 edges after accept.
REQ-041 Arithmetic:
- ADD 0xF0+0x20 gives y=0x10, carry=1.
- SUB 0x10-0x20 gives y=0xF0, carry=1.
- SUB 0x33-0x33 gives y=0x00, zero=1, carry=0.
REQ-042 Accumulate:
- ACC a=0x80, 0x80, 0x01 gives 0x80; 0x00 with carry=1; 0x01.
- ACC a=0x05 with acc_clr=1 gives 0x05.
REQ-043 Backpressure: out_ready=0 with continuous in_valid accepts 5 beats, then in_ready=0; releasing out_ready drains all 5 in order; simultaneous push and pop at full loses nothing.
REQ-044 Mid-op reset: with 3 results queued, pull sys_rst low for 1 cycle; then out_valid=0, op_count=0 and acc=0, and no stale result appears afterwards.
